// File: rtl/seq_detect_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_arbiter_if
// Description : Request/grant and detection-report bundle for the
//               round-robin "1011" sequence detector arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_detect_arbiter_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic [NCH-1:0]   req_valid;
    logic [NCH-1:0]   req_bit;
    logic [NCH-1:0]   req_ready;
    logic [NCH-1:0]   ctx_clr;
    logic             det_valid;
    logic [1:0]       det_chan;
    logic             det_hit;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_out;

    // Requesting side: presents serial bits, clears and counter selects
    modport master (
        output req_valid, req_bit, ctx_clr, cnt_sel,
        input  req_ready, det_valid, det_chan, det_hit, cnt_out
    );

    // Detector side
    modport slave (
        input  req_valid, req_bit, ctx_clr, cnt_sel,
        output req_ready, det_valid, det_chan, det_hit, cnt_out
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_arbiter
// Description : One shared overlapping "1011" Moore detector, time-multiplexed
//               over NCH serial channels by a round-robin arbiter. Each channel
//               keeps its own 3-bit detector context and saturating hit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_arbiter #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  wire logic           clock,
    input  wire logic           reset_n,
    seq_detect_arbiter_if.slave bus
);

    localparam int               C_PTR_W   = 2;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } ctx_e;

    ctx_e               r_ctx [NCH];
    logic [CNT_W-1:0]   r_cnt [NCH];
    logic [C_PTR_W-1:0] r_ptr;
    logic               r_det_valid;
    logic [1:0]         r_det_chan;
    logic               r_det_hit;

    logic [NCH-1:0]     w_eligible;
    logic [NCH-1:0]     w_grant;
    logic               w_gnt_any;
    logic [C_PTR_W-1:0] w_gnt_idx;
    logic [C_PTR_W-1:0] w_scan_idx;
    ctx_e               w_ctx_next;
    logic               w_hit;

    // Shared detector next-state function; S4 is the only hit state and
    // leaves toward S1/S2 so overlapping matches are found.
    function automatic ctx_e f_ctx_next(input ctx_e cur, input logic b);
        ctx_e nxt;
        case (cur)
            S0:      nxt = b ? S1 : S0;
            S1:      nxt = b ? S1 : S2;
            S2:      nxt = b ? S3 : S0;
            S3:      nxt = b ? S4 : S2;
            S4:      nxt = b ? S1 : S2;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    // A channel being cleared is never granted, and nothing is granted in reset
    assign w_eligible = bus.req_valid & ~bus.ctx_clr & {NCH{reset_n}};

    // Round-robin search starting at the pointer, first eligible channel wins
    always_comb begin
        w_grant    = '0;
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_scan_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            w_scan_idx = r_ptr + C_PTR_W'(k);
            if (!w_gnt_any && w_eligible[w_scan_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
        if (w_gnt_any) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    assign w_ctx_next = f_ctx_next(r_ctx[w_gnt_idx], bus.req_bit[w_gnt_idx]);
    assign w_hit      = w_gnt_any && (w_ctx_next == S4);

    // Per-channel context and counter; a clear overrides any grant update
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= S0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.ctx_clr[i]) begin
                    r_ctx[i] <= S0;
                    r_cnt[i] <= '0;
                end else if (w_gnt_any && (w_gnt_idx == C_PTR_W'(i))) begin
                    r_ctx[i] <= w_ctx_next;
                    if (w_hit && (r_cnt[i] != C_CNT_MAX)) begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Pointer moves past the granted channel; report registered one cycle later
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_det_valid <= 1'b0;
            r_det_chan  <= '0;
            r_det_hit   <= 1'b0;
        end else begin
            if (w_gnt_any) begin
                r_ptr <= w_gnt_idx + C_PTR_W'(1);
            end
            r_det_valid <= w_gnt_any;
            r_det_chan  <= w_gnt_any ? w_gnt_idx : 2'b00;
            r_det_hit   <= w_hit;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.det_valid = r_det_valid;
    assign bus.det_chan  = r_det_chan;
    assign bus.det_hit   = r_det_hit;
    assign bus.cnt_out   = r_cnt[bus.cnt_sel];

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_arbiter
// Description : Self-checking bench: directed scenarios plus randomized
//               traffic against a suffix-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_arbiter;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    seq_detect_arbiter_if #(.NCH(4), .CNT_W(8)) bus  ();
    seq_detect_arbiter_if #(.NCH(4), .CNT_W(2)) sbus ();

    seq_detect_arbiter #(.NCH(4), .CNT_W(8)) u_dut     (.clock(clock), .reset_n(reset_n), .bus(bus));
    seq_detect_arbiter #(.NCH(4), .CNT_W(2)) u_dut_sat (.clock(clock), .reset_n(reset_n), .bus(sbus));

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: last four consumed bits per channel, bits since clear,
    // hit counts and the round-robin priority pointer.
    int         m_ptr;
    logic [3:0] m_hist [4];
    int         m_len  [4];
    int         m_cnt  [4];
    int         exp_g;
    logic [3:0] exp_rdy;
    logic       exp_dv;
    logic [1:0] exp_dc;
    logic       exp_dh;
    logic [3:0] cur_b, cur_c;

    task automatic model_reset();
        m_ptr = 0;
        for (int ch = 0; ch < 4; ch++) begin
            m_hist[ch] = 4'b0000; m_len[ch] = 0; m_cnt[ch] = 0;
        end
        exp_dv = 1'b0; exp_dc = 2'b00; exp_dh = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        bus.req_valid  = '0; bus.req_bit  = '0; bus.ctx_clr  = '0; bus.cnt_sel  = '0;
        sbus.req_valid = '0; sbus.req_bit = '0; sbus.ctx_clr = '0; sbus.cnt_sel = '0;
        @(negedge clock);
        #2 reset_n = 1'b1;
        model_reset();
    endtask

    // Drive one cycle of inputs after the falling edge and predict the grant
    task automatic apply(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c,
                         input logic [1:0] sel);
        int idx;
        @(negedge clock);
        bus.req_valid = v; bus.req_bit = b; bus.ctx_clr = c; bus.cnt_sel = sel;
        cur_b = b; cur_c = c;
        exp_g = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (exp_g < 0 && v[idx] && !c[idx]) exp_g = idx;
        end
        exp_rdy = (exp_g >= 0) ? (4'b0001 << exp_g) : 4'b0000;
        #1;
    endtask

    // Let the rising edge happen and advance the model accordingly
    task automatic advance();
        @(posedge clock);
        exp_dv = 1'b0; exp_dc = 2'b00; exp_dh = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            if (cur_c[ch]) begin
                m_hist[ch] = 4'b0000; m_len[ch] = 0; m_cnt[ch] = 0;
            end
        end
        if (exp_g >= 0) begin
            m_hist[exp_g] = {m_hist[exp_g][2:0], cur_b[exp_g]};
            m_len[exp_g]  = m_len[exp_g] + 1;
            exp_dv = 1'b1;
            exp_dc = 2'(exp_g);
            exp_dh = (m_len[exp_g] >= 4) && (m_hist[exp_g] == 4'b1011);
            if (exp_dh && m_cnt[exp_g] < 255) m_cnt[exp_g] = m_cnt[exp_g] + 1;
            m_ptr = (exp_g + 1) % 4;
        end
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid  = 4'hF; bus.req_bit = 4'hF; bus.ctx_clr = '0; bus.cnt_sel = '0;
        sbus.req_valid = '0; sbus.req_bit = '0; sbus.ctx_clr = '0; sbus.cnt_sel = '0;
        repeat (2) @(negedge clock);
        n_total++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); else n_pass++;
        n_total++; if ({bus.det_valid, bus.det_chan, bus.det_hit} !== 4'b0000)
            $display("FAIL reset_det got=%b%b%b exp=0", bus.det_valid, bus.det_chan, bus.det_hit); else n_pass++;
        for (int s = 0; s < 4; s++) begin
            bus.cnt_sel = 2'(s); #1;
            n_total++; if (bus.cnt_out !== 8'd0) $display("FAIL reset_cnt sel=%0d got=%0d exp=0", s, bus.cnt_out); else n_pass++;
        end
        do_reset();
        apply(4'hF, 4'hF, 4'h0, 2'd0);
        n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL first_grant got=%b exp=0001", bus.req_ready); else n_pass++;
        advance();
        n_total++; if (bus.det_valid !== 1'b1 || bus.det_chan !== 2'd0)
            $display("FAIL first_report got=%b/%0d exp=1/0", bus.det_valid, bus.det_chan); else n_pass++;
    endtask

    task automatic test_single();
        logic [3:0] s;
        s = 4'b1011;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(4'b0001, {3'b000, s[3-i]}, 4'h0, 2'd0);
            n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL single_ready i=%0d got=%b exp=0001", i, bus.req_ready); else n_pass++;
            advance();
            n_total++; if (bus.det_valid !== 1'b1 || bus.det_chan !== 2'd0 || bus.det_hit !== (i == 3))
                $display("FAIL single_det i=%0d got=%b/%0d/%b exp=1/0/%b", i, bus.det_valid, bus.det_chan, bus.det_hit, (i == 3)); else n_pass++;
        end
        n_total++; if (bus.cnt_out !== 8'd1) $display("FAIL single_cnt got=%0d exp=1", bus.cnt_out); else n_pass++;
        apply(4'h0, 4'h0, 4'h0, 2'd0);
        advance();
        n_total++; if ({bus.det_valid, bus.det_chan, bus.det_hit} !== 4'b0000)
            $display("FAIL idle_det got=%b%b%b exp=0", bus.det_valid, bus.det_chan, bus.det_hit); else n_pass++;
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        s = 7'b1011011;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(4'b0100, {1'b0, s[6-i], 2'b00}, 4'h0, 2'd2);
            advance();
            n_total++; if (bus.det_chan !== 2'd2 || bus.det_hit !== (i == 3 || i == 6))
                $display("FAIL overlap_det i=%0d got=%0d/%b exp=2/%b", i, bus.det_chan, bus.det_hit, (i == 3 || i == 6)); else n_pass++;
        end
        n_total++; if (bus.cnt_out !== 8'd2) $display("FAIL overlap_cnt got=%0d exp=2", bus.cnt_out); else n_pass++;
    endtask

    task automatic test_fairness();
        logic [3:0] s;
        s = 4'b1011;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            apply(4'hF, s[3-k/4] ? 4'hF : 4'h0, 4'h0, 2'd0);
            n_total++; if (bus.req_ready !== (4'b0001 << (k % 4)))
                $display("FAIL fair_ready k=%0d got=%b exp=%b", k, bus.req_ready, 4'b0001 << (k % 4)); else n_pass++;
            advance();
            n_total++; if (bus.det_chan !== 2'(k % 4) || bus.det_hit !== (k >= 12))
                $display("FAIL fair_det k=%0d got=%0d/%b exp=%0d/%b", k, bus.det_chan, bus.det_hit, k % 4, (k >= 12)); else n_pass++;
        end
        for (int c = 0; c < 4; c++) begin
            bus.cnt_sel = 2'(c); #1;
            n_total++; if (bus.cnt_out !== 8'd1) $display("FAIL fair_cnt ch=%0d got=%0d exp=1", c, bus.cnt_out); else n_pass++;
        end
    endtask

    task automatic test_clear_collision();
        logic [5:0] s;
        logic [3:0] t;
        s = 6'b101101;
        t = 4'b1011;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(4'b0010, {2'b00, s[5-i], 1'b0}, 4'h0, 2'd1);
            advance();
        end
        n_total++; if (bus.cnt_out !== 8'd1) $display("FAIL clr_pre_cnt got=%0d exp=1", bus.cnt_out); else n_pass++;
        apply(4'b0001, 4'h0, 4'h0, 2'd1);
        advance();
        apply(4'b1010, 4'b1010, 4'b0010, 2'd1);
        n_total++; if (bus.req_ready !== 4'b1000) $display("FAIL clr_ready got=%b exp=1000", bus.req_ready); else n_pass++;
        advance();
        n_total++; if (bus.det_chan !== 2'd3 || bus.det_hit !== 1'b0)
            $display("FAIL clr_det got=%0d/%b exp=3/0", bus.det_chan, bus.det_hit); else n_pass++;
        n_total++; if (bus.cnt_out !== 8'd0) $display("FAIL clr_cnt got=%0d exp=0", bus.cnt_out); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            apply(4'b0010, {2'b00, t[3-i], 1'b0}, 4'h0, 2'd1);
            advance();
            n_total++; if (bus.det_chan !== 2'd1 || bus.det_hit !== (i == 3))
                $display("FAIL clr_after i=%0d got=%0d/%b exp=1/%b", i, bus.det_chan, bus.det_hit, (i == 3)); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] s;
        logic [3:0]  h;
        int          nbits, hits;
        s = 16'b1011011011011011;
        h = 4'b0000; nbits = 0; hits = 0;
        do_reset();
        sbus.cnt_sel = 2'd3;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clock);
            sbus.req_valid = 4'b1000; sbus.req_bit = {s[i], 3'b000};
            @(posedge clock); #1;
            h = {h[2:0], s[i]}; nbits++;
            if (nbits >= 4 && h == 4'b1011) hits++;
            n_total++; if (sbus.cnt_out !== 2'((hits > 3) ? 3 : hits))
                $display("FAIL sat_cnt bit=%0d got=%0d exp=%0d", nbits, sbus.cnt_out, (hits > 3) ? 3 : hits); else n_pass++;
        end
        n_total++; if (sbus.cnt_out !== 2'd3) $display("FAIL sat_final got=%0d exp=3", sbus.cnt_out); else n_pass++;
        @(negedge clock);
        sbus.req_valid = '0; sbus.req_bit = '0;
    endtask

    task automatic test_async_reset();
        logic [3:0] t;
        t = 4'b1011;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(4'b0001, {3'b000, t[3-i]}, 4'h0, 2'd0);
            advance();
        end
        #2 reset_n = 1'b0;
        #1;
        n_total++; if ({bus.det_valid, bus.det_chan, bus.det_hit} !== 4'b0000)
            $display("FAIL areset_det got=%b%b%b exp=0", bus.det_valid, bus.det_chan, bus.det_hit); else n_pass++;
        n_total++; if (bus.req_ready !== 4'b0000) $display("FAIL areset_ready got=%b exp=0000", bus.req_ready); else n_pass++;
        bus.req_valid = '0;
        #2 reset_n = 1'b1;
        model_reset();
        apply(4'b0001, 4'b0001, 4'h0, 2'd0);
        advance();
        n_total++; if (bus.det_valid !== 1'b1 || bus.det_hit !== 1'b0)
            $display("FAIL areset_partial got=%b/%b exp=1/0", bus.det_valid, bus.det_hit); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            apply(4'b0001, {3'b000, t[3-i]}, 4'h0, 2'd0);
            advance();
        end
        n_total++; if (bus.det_hit !== 1'b1 || bus.cnt_out !== 8'd1)
            $display("FAIL areset_full got=%b/%0d exp=1/1", bus.det_hit, bus.cnt_out); else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] v, b, c;
        logic [1:0] sel;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            v   = 4'($urandom);
            b   = 4'($urandom);
            sel = 2'($urandom);
            for (int ch = 0; ch < 4; ch++) c[ch] = ($urandom_range(0, 11) == 0);
            apply(v, b, c, sel);
            n_total++; if (bus.req_ready !== exp_rdy) $display("FAIL rand_ready n=%0d got=%b exp=%b", n, bus.req_ready, exp_rdy); else n_pass++;
            advance();
            n_total++; if (bus.det_valid !== exp_dv || bus.det_chan !== exp_dc || bus.det_hit !== exp_dh)
                $display("FAIL rand_det n=%0d got=%b/%0d/%b exp=%b/%0d/%b", n, bus.det_valid, bus.det_chan, bus.det_hit, exp_dv, exp_dc, exp_dh); else n_pass++;
            n_total++; if (bus.cnt_out !== 8'(m_cnt[sel])) $display("FAIL rand_cnt n=%0d sel=%0d got=%0d exp=%0d", n, sel, bus.cnt_out, m_cnt[sel]); else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_overlap();
        test_fairness();
        test_clear_collision();
        test_saturation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detect_arbiter.md
SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

Interface
REQ-001 Parameter NCH, default 4, number of requesting serial channels; fixed at 4 for this revision.
REQ-002 Parameter CNT_W, default 8, width of each per-channel hit counter.
REQ-003 Port clock, input, 1, single rising-edge clock for all state.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port req_valid, input, NCH, channel i presents a serial bit.
REQ-006 Port req_bit, input, NCH, serial data bit of channel i.
REQ-007 Port req_ready, output, NCH, one-hot grant; a bit is consumed when req_valid[i] and req_ready[i] are both high.
REQ-008 Port ctx_clr, input, NCH, synchronous clear of channel i detector context and hit counter.
REQ-009 Port det_valid, output, 1, pulses one cycle per consumed bit.
REQ-010 Port det_chan, output, 2, channel of the bit reported by det_valid.
REQ-011 Port det_hit, output, 1, high with det_valid when the reported bit completed "1011".
REQ-012 Port cnt_sel, input, 2, selects the hit counter to read.
REQ-013 Port cnt_out, output, CNT_W, combinational read of the selected channel's hit counter.

Function
REQ-014 One shared "1011" Moore detector next-state function SHALL be time-multiplexed over NCH channels; each channel keeps its own 3-bit context register.
REQ-015 Context encoding: S0=000, S1=001, S2=010, S3=011, S4=100; S4 is the only hit state.
REQ-016 Transitions (bit=1 / bit=0): S0->S1/S0; S1->S1/S2; S2->S3/S0; S3->S4/S2; S4->S1/S2; unused encodings -> S0.
REQ-017 Overlap: detection is overlapping, so "1011011" yields two hits.
REQ-018 Arbitration: round-robin; at most one req_ready bit is high per cycle; req_ready SHALL be combinational from req_valid, ctx_clr and the pointer.
REQ-019 The highest-priority channel is the pointer; the search order is pointer, pointer+1, ... modulo NCH.
REQ-020 After a grant to channel i, the pointer SHALL become (i+1) mod NCH; with no grant, the pointer holds.
REQ-021 A channel with ctx_clr high SHALL NOT be granted that cycle; arbitration skips it.
REQ-022 On a grant, only the granted channel's context SHALL update, at the clock edge, using req_bit.
REQ-023 Latency: det_valid, det_chan and det_hit SHALL be registered and asserted on the cycle after the grant.
REQ-024 det_hit SHALL be 1 when the granted channel's new context is S4.
REQ-025 Counter: the channel's hit counter increments on each hit and saturates at 2^CNT_W-1 without wrapping.
REQ-026 Clear: ctx_clr[i] sets context i to S0 and counter i to 0 at the next edge; other channels are unaffected.
REQ-027 Clear has priority over any increment on the same channel.
REQ-028 Simultaneous valids on all channels SHALL each be served exactly once per NCH cycles; no starvation.
REQ-029 det_chan and det_hit SHALL be 0 whenever det_valid is 0.

Reset
REQ-030 reset_n low SHALL asynchronously force all of the following: all contexts S0, all counters 0, pointer 0, det_valid/det_chan/det_hit 0.
REQ-031 During reset req_ready SHALL be all zeros; no bit is consumed.
REQ-032 Reset asserted mid-sequence discards partial matches: after release, "011" alone on that channel SHALL NOT hit.
REQ-033 Deassertion is synchronized externally; the first grant can occur on the first edge after release.

Verification
REQ-034 Single channel: ch0 valid only, bits 1,0,1,1 -> four grants; det_hit=1 only on the 4th report, det_chan=0; cnt_sel=0 -> cnt_out=1.
REQ-035 Overlap: ch2 bits 1,0,1,1,0,1,1 -> hits on the 4th and 7th reports; counter=2.
REQ-036 Fairness: all four valid continuously from reset -> grant order 0,1,2,3,0,...; each channel's context advances once per 4 cycles; interleaved "1011" streams give one hit each at cycles 13-16 reports.
REQ-037 Clear collision: ch1 at S3, ctx_clr[1]=1 with req_valid[1]=1, bit=1 -> req_ready[1]=0, no hit, context S0, counter 0; the grant goes to the next valid channel.
REQ-038 Saturation: CNT_W=2, drive 5 hits on ch3 -> cnt_out sticks at 3.
REQ-039 Async reset: pulse reset_n low between clock edges after "101" on ch0 -> outputs 0 immediately; subsequent "1" gives no hit, full "1011" hits.
